// File: rtl/iob_ila_pretrig_core_pkg.sv
// Shared definitions for the pre-trigger ILA capture core: state encoding and
// read-select width helper.
package iob_ila_pretrig_core_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StDone  = 3'd4
  } ila_state_e;

  // Width of the slice selector: enough bits to address every DATA_W slice
  // of a SIGNAL_W sample, never less than one bit.
  function automatic int unsigned calc_sel_w(int unsigned data_w, int unsigned signal_w);
    int unsigned n_slice;
    n_slice = (signal_w + data_w - 1) / data_w;
    if (n_slice <= 2) return 1;
    return $clog2(n_slice);
  endfunction

endpackage

// File: rtl/iob_ila_pretrig_core_if.sv
// Control, trigger-configuration, sample and readout bundle between the ILA
// register file (master) and the capture core (slave).
interface iob_ila_pretrig_core_if
  import iob_ila_pretrig_core_pkg::*;
#(
  parameter int unsigned SIGNAL_W  = 32,
  parameter int unsigned TRIGGER_W = 4,
  parameter int unsigned BUFFER_W  = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SEL_W     = calc_sel_w(DATA_W, SIGNAL_W)
) ();

  logic                 sample_en;
  logic [SIGNAL_W-1:0]  signal;
  logic [TRIGGER_W-1:0] trigger;
  logic                 arm;
  logic                 disarm;
  logic                 force_trig;
  logic [TRIGGER_W-1:0] trig_type;
  logic [TRIGGER_W-1:0] trig_negate;
  logic [TRIGGER_W-1:0] trig_mask;
  logic                 trig_and;
  logic [BUFFER_W-1:0]  pretrig;
  logic [BUFFER_W-1:0]  rd_index;
  logic [SEL_W-1:0]     rd_select;
  logic [DATA_W-1:0]    rd_data;
  logic [2:0]           state;
  logic [BUFFER_W:0]    samples;
  logic [BUFFER_W-1:0]  trig_pos;
  logic                 done;

  modport master (
    output sample_en, signal, trigger, arm, disarm, force_trig,
    output trig_type, trig_negate, trig_mask, trig_and, pretrig,
    output rd_index, rd_select,
    input  rd_data, state, samples, trig_pos, done
  );

  modport slave (
    input  sample_en, signal, trigger, arm, disarm, force_trig,
    input  trig_type, trig_negate, trig_mask, trig_and, pretrig,
    input  rd_index, rd_select,
    output rd_data, state, samples, trig_pos, done
  );

endinterface

// File: rtl/iob_ila_pretrig_core_trig_eval.sv
// Trigger evaluation: per-bit level/rising-edge detection with optional
// inversion, combined by AND or OR over the enabled bits.
module iob_ila_pretrig_core_trig_eval #(
  parameter int unsigned TRIGGER_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic [TRIGGER_W-1:0] trigger,
  input  logic [TRIGGER_W-1:0] trig_type,
  input  logic [TRIGGER_W-1:0] trig_negate,
  input  logic [TRIGGER_W-1:0] trig_mask,
  input  logic                 trig_and,
  output logic                 hit
);

  logic [TRIGGER_W-1:0] cur;
  logic [TRIGGER_W-1:0] hist_q;
  logic [TRIGGER_W-1:0] bits;

  assign cur  = trigger ^ trig_negate;
  // Edge bits compare against the value seen at the previous qualified sample.
  assign bits = (trig_type & cur & ~hist_q) | (~trig_type & cur);

  // Edge history, advanced only on qualified samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else if (sample_en) begin
      hist_q <= cur;
    end
  end

  // Combine enabled bits; an empty mask never hits.
  always_comb begin
    hit = 1'b0;
    if (|trig_mask) begin
      hit = trig_and ? &(bits | ~trig_mask) : |(bits & trig_mask);
    end
  end

endmodule

// File: rtl/iob_ila_pretrig_core.sv
// ILA capture core: circular sample buffer with programmable pre-trigger
// window, trigger combining, force trigger and oldest-relative readout.
module iob_ila_pretrig_core
  import iob_ila_pretrig_core_pkg::*;
#(
  parameter int unsigned SIGNAL_W  = 32,
  parameter int unsigned TRIGGER_W = 4,
  parameter int unsigned BUFFER_W  = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SEL_W     = calc_sel_w(DATA_W, SIGNAL_W)
) (
  input logic                   clk,
  input logic                   rst,
  iob_ila_pretrig_core_if.slave ila
);

  localparam int unsigned Depth  = 2 ** BUFFER_W;
  localparam int unsigned NSlice = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam logic [BUFFER_W:0] DepthCnt = {1'b1, {BUFFER_W{1'b0}}};

  ila_state_e          state_q, state_d;
  logic [BUFFER_W-1:0] wptr_q, wptr_d;
  logic [BUFFER_W:0]   samples_q, samples_d;
  logic [BUFFER_W-1:0] pre_q, pre_d;
  logic [BUFFER_W-1:0] trig_slot_q, trig_slot_d;
  logic [BUFFER_W-1:0] remain_q, remain_d;
  logic                force_pend_q, force_pend_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic                we;
  logic                hit;
  logic [BUFFER_W-1:0] pt;
  logic [BUFFER_W:0]   samples_inc;
  logic [BUFFER_W-1:0] pre_cap;
  logic [BUFFER_W-1:0] post_len;
  logic [BUFFER_W-1:0] rd_addr;
  logic [NSlice*DATA_W-1:0] padded;
  logic [DATA_W-1:0]   slice;

  logic [SIGNAL_W-1:0] mem [Depth];

  iob_ila_pretrig_core_trig_eval #(
    .TRIGGER_W (TRIGGER_W)
  ) u_trig_eval (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (ila.sample_en),
    .trigger     (ila.trigger),
    .trig_type   (ila.trig_type),
    .trig_negate (ila.trig_negate),
    .trig_mask   (ila.trig_mask),
    .trig_and    (ila.trig_and),
    .hit         (hit)
  );

  // The pretrig port is BUFFER_W wide, so it can never exceed DEPTH-1.
  assign pt          = ila.pretrig;
  assign samples_inc = (samples_q == DepthCnt) ? samples_q : samples_q + 1'b1;
  assign pre_cap     = (samples_q < {1'b0, pt}) ? samples_q[BUFFER_W-1:0] : pt;
  assign post_len    = {BUFFER_W{1'b1}} - pt;

  // Capture sequencing: disarm beats arm, arm restarts from any state.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    samples_d    = samples_q;
    pre_d        = pre_q;
    trig_slot_d  = trig_slot_q;
    remain_d     = remain_q;
    force_pend_d = force_pend_q;
    we           = 1'b0;
    if (ila.disarm) begin
      state_d      = StIdle;
      force_pend_d = 1'b0;
    end else if (ila.arm) begin
      wptr_d       = '0;
      samples_d    = '0;
      pre_d        = '0;
      trig_slot_d  = '0;
      force_pend_d = 1'b0;
      state_d      = (pt == '0) ? StArmed : StFill;
    end else begin
      unique case (state_q)
        StIdle, StDone: ;
        StFill: begin
          if (ila.sample_en) begin
            we        = 1'b1;
            wptr_d    = wptr_q + 1'b1;
            samples_d = samples_inc;
            if (samples_inc >= {1'b0, pt}) state_d = StArmed;
          end
        end
        StArmed: begin
          if (ila.sample_en) begin
            we        = 1'b1;
            wptr_d    = wptr_q + 1'b1;
            samples_d = samples_inc;
            if (hit || ila.force_trig || force_pend_q) begin
              trig_slot_d  = wptr_q;
              pre_d        = pre_cap;
              remain_d     = post_len;
              force_pend_d = 1'b0;
              // With a full pre-trigger window there is nothing left to collect.
              state_d      = (post_len == '0) ? StDone : StPost;
            end
          end else if (ila.force_trig) begin
            force_pend_d = 1'b1;
          end
        end
        StPost: begin
          if (ila.sample_en) begin
            we        = 1'b1;
            wptr_d    = wptr_q + 1'b1;
            samples_d = samples_inc;
            remain_d  = remain_q - 1'b1;
            if (remain_q == 1) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      samples_q    <= '0;
      pre_q        <= '0;
      trig_slot_q  <= '0;
      remain_q     <= '0;
      force_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      samples_q    <= samples_d;
      pre_q        <= pre_d;
      trig_slot_q  <= trig_slot_d;
      remain_q     <= remain_d;
      force_pend_q <= force_pend_d;
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wptr_q] <= ila.signal;
  end

  // Oldest-relative addressing and slice selection; unused top bits read as zero.
  assign rd_addr = trig_slot_q - pre_q + ila.rd_index;
  always_comb begin
    padded                = '0;
    padded[SIGNAL_W-1:0]  = mem[rd_addr];
    slice                 = '0;
    if (int'(ila.rd_select) < int'(NSlice)) begin
      slice = DATA_W'(padded >> (int'(ila.rd_select) * int'(DATA_W)));
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= slice;
  end

  assign ila.rd_data  = rd_data_q;
  assign ila.state    = state_q;
  assign ila.samples  = samples_q;
  assign ila.trig_pos = pre_q;
  assign ila.done     = (state_q == StDone);

endmodule

// File: tb/tb_iob_ila_pretrig_core.sv
// Self-checking bench for iob_ila_pretrig_core with a queue-based capture model.
module tb_iob_ila_pretrig_core;
  import iob_ila_pretrig_core_pkg::*;

  localparam int unsigned SIGNAL_W  = 40;
  localparam int unsigned TRIGGER_W = 4;
  localparam int unsigned BUFFER_W  = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_W     = calc_sel_w(DATA_W, SIGNAL_W);
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  iob_ila_pretrig_core_if #(
    .SIGNAL_W (SIGNAL_W), .TRIGGER_W (TRIGGER_W), .BUFFER_W (BUFFER_W),
    .DATA_W (DATA_W), .SEL_W (SEL_W)
  ) ila ();

  iob_ila_pretrig_core #(
    .SIGNAL_W (SIGNAL_W), .TRIGGER_W (TRIGGER_W), .BUFFER_W (BUFFER_W),
    .DATA_W (DATA_W), .SEL_W (SEL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ila (ila)
  );

  always #5 clk = ~clk;

  // Reference model: chronological list of every stored sample since arm.
  int m_state, m_samples, m_trig_pos, m_tidx, m_remain;
  bit m_fpend;
  logic [TRIGGER_W-1:0] m_prev;
  logic [SIGNAL_W-1:0] m_hist[$];

  task automatic model_reset();
    m_state = 0; m_samples = 0; m_trig_pos = 0; m_tidx = 0; m_remain = 0;
    m_fpend = 0; m_prev = '0;
  endtask

  task automatic model_store();
    m_hist.push_back(ila.signal);
    if (m_samples < DEPTH) m_samples++;
  endtask

  task automatic model_cycle();
    logic [TRIGGER_W-1:0] cur, bits;
    bit hit;
    int pt;
    pt  = int'(ila.pretrig);
    cur = ila.trigger ^ ila.trig_negate;
    for (int b = 0; b < int'(TRIGGER_W); b++)
      bits[b] = ila.trig_type[b] ? (cur[b] && !m_prev[b]) : cur[b];
    if (ila.trig_mask == '0) hit = 0;
    else if (ila.trig_and) hit = ((bits & ila.trig_mask) == ila.trig_mask);
    else hit = ((bits & ila.trig_mask) != '0);
    if (ila.sample_en) m_prev = cur;
    if (ila.disarm) begin
      m_state = 0; m_fpend = 0;
    end else if (ila.arm) begin
      m_hist.delete(); m_samples = 0; m_trig_pos = 0; m_tidx = 0; m_fpend = 0;
      m_state = (pt == 0) ? 2 : 1;
    end else begin
      case (m_state)
        1: if (ila.sample_en) begin
          model_store();
          if (m_samples >= pt) m_state = 2;
        end
        2: if (ila.sample_en) begin
          if (hit || ila.force_trig || m_fpend) begin
            m_trig_pos = (m_samples < pt) ? m_samples : pt;
            m_tidx = m_hist.size();
            m_remain = DEPTH - pt - 1;
            m_fpend = 0;
            m_state = (m_remain == 0) ? 4 : 3;
          end
          model_store();
        end else if (ila.force_trig) m_fpend = 1;
        3: if (ila.sample_en) begin
          model_store();
          m_remain--;
          if (m_remain == 0) m_state = 4;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_slice(int idx, int sel);
    logic [63:0] w;
    int pos;
    pos = m_tidx - m_trig_pos + idx;
    if (pos < 0 || pos >= m_hist.size()) return '0;
    w = 64'(m_hist[pos]);
    return (sel == 0) ? w[31:0] : w[63:32];
  endfunction

  task automatic cycle();
    if (rst) model_reset();
    else model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [TRIGGER_W-1:0] trig);
    ila.signal = {8'($urandom), 32'($urandom)};
    ila.trigger = trig;
    ila.sample_en = 1'b1;
    cycle();
    ila.sample_en = 1'b0;
    repeat ($urandom_range(0, 1)) cycle();
  endtask

  task automatic pulse_arm();
    ila.arm = 1'b1; cycle(); ila.arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    ila.disarm = 1'b1; cycle(); ila.disarm = 1'b0;
  endtask

  task automatic config_trig(input logic [3:0] typ, input logic [3:0] neg, input logic [3:0] msk,
                             input logic andm, input int pt);
    ila.trig_type = typ; ila.trig_negate = neg; ila.trig_mask = msk; ila.trig_and = andm;
    ila.pretrig = BUFFER_W'(pt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    checks++; if (ila.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", ila.state); end
    checks++; if (ila.samples !== '0) begin errors++; $display("FAIL reset_samples: got %0d want 0", ila.samples); end
    checks++; if (ila.trig_pos !== '0) begin errors++; $display("FAIL reset_trig_pos: got %0d want 0", ila.trig_pos); end
    checks++; if (ila.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", ila.done); end
    checks++; if (ila.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h want 0", ila.rd_data); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_level_trig();
    config_trig(4'b0000, 4'b0000, 4'b0001, 1'b0, 4);
    pulse_arm();
    for (int i = 0; i < 4; i++) sample(4'b1111);  // ignored while filling
    checks++; if (ila.state !== 3'd2) begin errors++; $display("FAIL level_armed: got %0d want 2", ila.state); end
    for (int i = 4; i < 10; i++) sample(4'($urandom) & 4'b1110);
    sample(4'b0001);
    checks++; if (ila.state !== 3'd3) begin errors++; $display("FAIL level_post: got %0d want 3", ila.state); end
    for (int i = 0; i < 10; i++) sample(4'($urandom));
    checks++; if (ila.state !== 3'd3) begin errors++; $display("FAIL level_still_post: got %0d want 3", ila.state); end
    sample(4'($urandom));
    checks++; if (ila.done !== 1'b1) begin errors++; $display("FAIL level_done: got %0b want 1", ila.done); end
    checks++; if (ila.trig_pos !== 4'd4) begin errors++; $display("FAIL level_trig_pos: got %0d want 4", ila.trig_pos); end
    checks++; if (ila.samples !== 5'd16) begin errors++; $display("FAIL level_samples: got %0d want 16", ila.samples); end
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        ila.rd_index = BUFFER_W'(i); ila.rd_select = SEL_W'(s);
        cycle();
        checks++;
        if (ila.rd_data !== exp_slice(i, s)) begin
          errors++;
          $display("FAIL level_read[%0d.%0d]: got %0h want %0h", i, s, ila.rd_data, exp_slice(i, s));
        end
      end
    end
    // Index 4 holds the trigger sample (the 11th stored).
    ila.rd_index = 4'd4; ila.rd_select = '0;
    cycle();
    checks++;
    if (ila.rd_data !== m_hist[10][31:0]) begin
      errors++; $display("FAIL level_trig_sample: got %0h want %0h", ila.rd_data, m_hist[10][31:0]);
    end
  endtask

  task automatic test_edge_negate();
    pulse_disarm();
    config_trig(4'b0010, 4'b0010, 4'b0010, 1'b0, 0);
    sample(4'b0000); sample(4'b0000);
    pulse_arm();
    for (int i = 0; i < 5; i++) sample(4'b0000);
    checks++; if (ila.state !== 3'd2) begin errors++; $display("FAIL edge_held_low: got %0d want 2", ila.state); end
    sample(4'b0010);
    checks++; if (ila.state !== 3'd2) begin errors++; $display("FAIL edge_rise_raw: got %0d want 2", ila.state); end
    sample(4'b0000);
    checks++; if (ila.state !== 3'd3) begin errors++; $display("FAIL edge_fall_hit: got %0d want 3", ila.state); end
    pulse_disarm();
  endtask

  task automatic test_and();
    config_trig(4'b0000, 4'b0000, 4'b0011, 1'b1, 2);
    pulse_arm();
    sample(4'b0000); sample(4'b0000);
    sample(4'b0001);
    sample(4'b0010);
    checks++; if (ila.state !== 3'd2) begin errors++; $display("FAIL and_split: got %0d want 2", ila.state); end
    sample(4'b0011);
    checks++; if (ila.state !== 3'd3) begin errors++; $display("FAIL and_both: got %0d want 3", ila.state); end
    for (int i = 0; i < 13; i++) sample(4'($urandom));
    checks++; if (ila.state !== 3'(m_state)) begin errors++; $display("FAIL and_done: got %0d want %0d", ila.state, m_state); end
    checks++; if (ila.trig_pos !== 4'd2) begin errors++; $display("FAIL and_trig_pos: got %0d want 2", ila.trig_pos); end
    for (int i = 0; i < DEPTH; i++) begin
      ila.rd_index = BUFFER_W'(i); ila.rd_select = SEL_W'(i % 2);
      cycle();
      checks++;
      if (ila.rd_data !== exp_slice(i, i % 2)) begin
        errors++; $display("FAIL and_read[%0d]: got %0h want %0h", i, ila.rd_data, exp_slice(i, i % 2));
      end
    end
  endtask

  task automatic test_force();
    config_trig(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    pulse_arm();
    ila.force_trig = 1'b1; cycle(); ila.force_trig = 1'b0;
    cycle();
    checks++; if (ila.state !== 3'd2) begin errors++; $display("FAIL force_pending: got %0d want 2", ila.state); end
    sample(4'b0000);
    checks++; if (ila.state !== 3'd3) begin errors++; $display("FAIL force_post: got %0d want 3", ila.state); end
    checks++; if (ila.trig_pos !== 4'd0) begin errors++; $display("FAIL force_trig_pos: got %0d want 0", ila.trig_pos); end
    for (int i = 0; i < 15; i++) sample(4'b0000);
    checks++; if (ila.done !== 1'b1) begin errors++; $display("FAIL force_done: got %0b want 1", ila.done); end
    checks++; if (ila.samples !== 5'd16) begin errors++; $display("FAIL force_samples: got %0d want 16", ila.samples); end
    ila.rd_index = '0; ila.rd_select = '0;
    cycle();
    checks++;
    if (ila.rd_data !== m_hist[0][31:0]) begin
      errors++; $display("FAIL force_read0: got %0h want %0h", ila.rd_data, m_hist[0][31:0]);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] big;
    big = 8'd255;
    config_trig(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    ila.pretrig = BUFFER_W'(big);
    pulse_arm();
    for (int i = 0; i < 15; i++) sample(4'b0000);
    checks++; if (ila.state !== 3'd2) begin errors++; $display("FAIL clamp_armed: got %0d want 2", ila.state); end
    sample(4'b0000); sample(4'b0000);
    ila.force_trig = 1'b1; sample(4'b0000); ila.force_trig = 1'b0;
    checks++; if (ila.state !== 3'd4) begin errors++; $display("FAIL clamp_done: got %0d want 4", ila.state); end
    checks++; if (ila.trig_pos !== 4'd15) begin errors++; $display("FAIL clamp_trig_pos: got %0d want 15", ila.trig_pos); end
    for (int i = 0; i < DEPTH; i++) begin
      ila.rd_index = BUFFER_W'(i); ila.rd_select = SEL_W'(1);
      cycle();
      checks++;
      if (ila.rd_data !== exp_slice(i, 1)) begin
        errors++; $display("FAIL clamp_read[%0d]: got %0h want %0h", i, ila.rd_data, exp_slice(i, 1));
      end
    end
    ila.rd_index = 4'd15; ila.rd_select = '0;
    cycle();
    checks++;
    if (ila.rd_data !== m_hist[17][31:0]) begin
      errors++; $display("FAIL clamp_trig_sample: got %0h want %0h", ila.rd_data, m_hist[17][31:0]);
    end
  endtask

  task automatic test_disarm_post();
    config_trig(4'b0000, 4'b0000, 4'b0001, 1'b0, 4);
    pulse_arm();
    for (int i = 0; i < 4; i++) sample(4'b0000);
    sample(4'b0001);
    for (int i = 0; i < 3; i++) sample(4'b0000);
    pulse_disarm();
    checks++; if (ila.state !== 3'd0) begin errors++; $display("FAIL disarm_idle: got %0d want 0", ila.state); end
    checks++; if (ila.samples !== 5'd8) begin errors++; $display("FAIL disarm_samples: got %0d want 8", ila.samples); end
    ila.arm = 1'b1; ila.disarm = 1'b1; cycle(); ila.arm = 1'b0; ila.disarm = 1'b0;
    checks++; if (ila.state !== 3'd0) begin errors++; $display("FAIL arm_disarm_idle: got %0d want 0", ila.state); end
    checks++; if (ila.samples !== 5'(m_samples)) begin errors++; $display("FAIL arm_disarm_samples: got %0d want %0d", ila.samples, m_samples); end
  endtask

  task automatic test_rst_post();
    config_trig(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    pulse_arm();
    ila.force_trig = 1'b1; sample(4'b0000); ila.force_trig = 1'b0;
    sample(4'b0000); sample(4'b0000);
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++; if (ila.state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", ila.state); end
    checks++; if (ila.samples !== '0) begin errors++; $display("FAIL rst_samples: got %0d want 0", ila.samples); end
    checks++; if (ila.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", ila.done); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      config_trig(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 15));
      pulse_arm();
      for (int c = 0; c < 150 && m_state != 4; c++) begin
        ila.sample_en  = ($urandom_range(0, 3) != 0);
        ila.signal     = {8'($urandom), 32'($urandom)};
        ila.trigger    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
        ila.force_trig = ($urandom_range(0, 40) == 0);
        cycle();
        checks++;
        if (ila.state !== 3'(m_state) || ila.samples !== 5'(m_samples) ||
            ila.trig_pos !== 4'(m_trig_pos)) begin
          errors++;
          $display("FAIL rand_status r%0d c%0d: got st=%0d n=%0d tp=%0d want st=%0d n=%0d tp=%0d",
                   r, c, ila.state, ila.samples, ila.trig_pos, m_state, m_samples, m_trig_pos);
        end
      end
      ila.sample_en = 1'b0; ila.force_trig = 1'b0; ila.trigger = '0;
      if (m_state == 4) begin
        for (int i = 0; i < m_samples; i++) begin
          ila.rd_index = BUFFER_W'(i); ila.rd_select = SEL_W'($urandom_range(0, 1));
          cycle();
          checks++;
          if (ila.rd_data !== exp_slice(i, int'(ila.rd_select))) begin
            errors++;
            $display("FAIL rand_read r%0d[%0d]: got %0h want %0h", r, i, ila.rd_data,
                     exp_slice(i, int'(ila.rd_select)));
          end
        end
      end
      pulse_disarm();
    end
  endtask

  initial begin
    ila.sample_en = 1'b0; ila.signal = '0; ila.trigger = '0;
    ila.arm = 1'b0; ila.disarm = 1'b0; ila.force_trig = 1'b0;
    ila.trig_type = '0; ila.trig_negate = '0; ila.trig_mask = '0; ila.trig_and = 1'b0;
    ila.pretrig = '0; ila.rd_index = '0; ila.rd_select = '0;
    model_reset();
    test_reset();
    test_level_trig();
    test_edge_negate();
    test_and();
    test_force();
    test_clamp();
    test_disarm_post();
    test_rst_post();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
